// File: rtl/nmr_pulse_sequencer.sv
// Segment-table pulse sequencer: steps the DDS frequency word through a programmed
// list of segments, gating the transmit path and firing acquisition triggers.
module nmr_pulse_sequencer #(
  parameter int N_SEG  = 8,
  parameter int SEG_AW = 3,
  parameter int DUR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [SEG_AW-1:0] cfg_addr,
  input  logic [31:0]       cfg_frq,
  input  logic [DUR_W-1:0]  cfg_dur,
  input  logic [1:0]        cfg_flags,
  input  logic [SEG_AW:0]   seq_len,
  input  logic [15:0]       rep_count,
  input  logic              start,
  input  logic              abort,
  input  logic              dds_valid,
  output logic [31:0]       frq_out,
  output logic              tx_gate,
  output logic              acq_trig,
  output logic              busy,
  output logic              done,
  output logic [SEG_AW-1:0] seg_idx,
  output logic [15:0]       rep_idx
);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DONE} state_t;

  state_t             state;
  logic [31:0]        tbl_frq   [N_SEG];
  logic [DUR_W-1:0]   tbl_dur   [N_SEG];
  logic [1:0]         tbl_flags [N_SEG];
  logic [DUR_W-1:0]   cnt;
  logic [SEG_AW-1:0]  seg_last;
  logic [15:0]        rep_last;
  logic [1:0]         cur_flags;
  logic               seq_ok;

  assign seq_ok = (seq_len != '0) && (seq_len <= (SEG_AW+1)'(N_SEG));

  // The table is frozen while a sequence plays so a segment can never change mid-run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SEG; i++) begin
        tbl_frq[i]   <= '0;
        tbl_dur[i]   <= '0;
        tbl_flags[i] <= '0;
      end
    end else if (cfg_we && !busy) begin
      tbl_frq[cfg_addr]   <= cfg_frq;
      tbl_dur[cfg_addr]   <= cfg_dur;
      tbl_flags[cfg_addr] <= cfg_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      frq_out   <= '0;
      tx_gate   <= 1'b0;
      acq_trig  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seg_idx   <= '0;
      rep_idx   <= '0;
      cnt       <= '0;
      seg_last  <= '0;
      rep_last  <= '0;
      cur_flags <= '0;
    end else begin
      acq_trig <= 1'b0;
      done     <= 1'b0;
      if (abort && state != IDLE) begin
        state   <= IDLE;
        tx_gate <= 1'b0;
        frq_out <= '0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort && seq_ok) begin
              seg_last <= SEG_AW'(seq_len - 1'b1);
              rep_last <= (rep_count == 16'd0) ? 16'd0 : rep_count - 16'd1;
              seg_idx  <= '0;
              rep_idx  <= '0;
              busy     <= 1'b1;
              state    <= LOAD;
            end
          end
          LOAD: begin
            frq_out   <= tbl_frq[seg_idx];
            cnt       <= (tbl_dur[seg_idx] == '0) ? DUR_W'(1) : tbl_dur[seg_idx];
            cur_flags <= tbl_flags[seg_idx];
            tx_gate   <= 1'b0;
            state     <= SETTLE;
          end
          SETTLE: begin
            if (dds_valid) begin
              tx_gate  <= cur_flags[0];
              acq_trig <= cur_flags[1];
              state    <= RUN;
            end
          end
          // The counter stops at 1, so the last RUN cycle closes the gate without wrapping.
          RUN: begin
            if (cnt > DUR_W'(1)) begin
              cnt <= cnt - DUR_W'(1);
            end else begin
              tx_gate <= 1'b0;
              if (seg_idx != seg_last) begin
                seg_idx <= seg_idx + 1'b1;
                state   <= LOAD;
              end else if (rep_idx != rep_last) begin
                rep_idx <= rep_idx + 16'd1;
                seg_idx <= '0;
                state   <= LOAD;
              end else begin
                state <= DONE;
              end
            end
          end
          DONE: begin
            done    <= 1'b1;
            frq_out <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nmr_pulse_sequencer.sv
// Directed bench for nmr_pulse_sequencer: runs hand-timed sequences and compares
// gate pulse lengths, triggers and register values against fixed expectations.
module tb_nmr_pulse_sequencer;

  localparam logic [31:0] FRQ_A = 32'h0CCCCCCD;
  localparam logic [31:0] FRQ_B = 32'h11111111;
  localparam logic [31:0] FRQ_C = 32'h22222222;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_frq;
  logic [31:0] cfg_dur;
  logic [1:0]  cfg_flags;
  logic [3:0]  seq_len;
  logic [15:0] rep_count;
  logic        start;
  logic        abort;
  logic        dds_valid;
  logic [31:0] frq_out;
  logic        tx_gate;
  logic        acq_trig;
  logic        busy;
  logic        done;
  logic [2:0]  seg_idx;
  logic [15:0] rep_idx;

  int          vectors;
  int          miscompares;
  int          pulses[$];
  int          acq_cnt;
  int          done_cnt;
  int          max_rep;
  int          extra_done;
  int          tx_highs;
  logic [31:0] frq_or;
  logic        seen_done;

  nmr_pulse_sequencer #(.N_SEG(8), .SEG_AW(3), .DUR_W(32)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_frq(cfg_frq),
    .cfg_dur(cfg_dur), .cfg_flags(cfg_flags), .seq_len(seq_len), .rep_count(rep_count),
    .start(start), .abort(abort), .dds_valid(dds_valid), .frq_out(frq_out),
    .tx_gate(tx_gate), .acq_trig(acq_trig), .busy(busy), .done(done),
    .seg_idx(seg_idx), .rep_idx(rep_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic do_start, input logic do_abort);
    start = do_start;
    abort = do_abort;
    stepCycle();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic writeSeg(input logic [2:0] addr, input logic [31:0] frq, input logic [31:0] dur,
                          input logic [1:0] flags);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_frq   = frq;
    cfg_dur   = dur;
    cfg_flags = flags;
    stepCycle();
    cfg_we = 1'b0;
  endtask

  // Steps until done, recording each tx_gate high run length and trigger counts.
  task automatic watchRun(input int max_cycles);
    int cur;
    pulses.delete();
    acq_cnt   = 0;
    done_cnt  = 0;
    max_rep   = 0;
    frq_or    = '0;
    seen_done = 1'b0;
    cur = tx_gate ? 1 : 0;
    for (int i = 0; i < max_cycles && !seen_done; i++) begin
      stepCycle();
      if (tx_gate) cur++;
      else if (cur > 0) begin
        pulses.push_back(cur);
        cur = 0;
      end
      if (acq_trig) acq_cnt++;
      if (done) begin
        done_cnt++;
        seen_done = 1'b1;
      end
      if (int'(rep_idx) > max_rep) max_rep = int'(rep_idx);
      frq_or |= frq_out;
    end
    if (cur > 0) pulses.push_back(cur);
    checkOutput("run_done_seen", seen_done, 1'b1);
  endtask

  task automatic countExtraDone(input int n);
    extra_done = 0;
    for (int i = 0; i < n; i++) begin
      stepCycle();
      if (done) extra_done++;
    end
  endtask

  function automatic int pulseAt(input int i);
    return (i < pulses.size()) ? pulses[i] : -1;
  endfunction

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_frq = '0; cfg_dur = '0; cfg_flags = '0;
    seq_len = 4'd1; rep_count = 16'd1; start = 1'b0; abort = 1'b0; dds_valid = 1'b1;
    #13;
    checkOutput("rst_frq_out", frq_out, 32'h0);
    checkOutput("rst_tx_gate", tx_gate, 1'b0);
    checkOutput("rst_acq_trig", acq_trig, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_seg_idx", seg_idx, 3'd0);
    checkOutput("rst_rep_idx", rep_idx, 16'd0);
    rst = 1'b0;
    stepCycle();

    // Single 10-cycle segment.
    writeSeg(3'd0, FRQ_A, 32'd10, 2'b11);
    seq_len = 4'd1; rep_count = 16'd1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1_busy_after_start", busy, 1'b1);
    stepCycle();
    checkOutput("t1_frq_loaded", frq_out, FRQ_A);
    watchRun(100);
    checkOutput("t1_pulse_count", pulses.size(), 1);
    checkOutput("t1_pulse_len", pulseAt(0), 10);
    checkOutput("t1_acq_count", acq_cnt, 1);
    checkOutput("t1_frq_after_done", frq_out, 32'h0);
    checkOutput("t1_busy_after_done", busy, 1'b0);

    // Three segments, two repetitions; the zero-duration middle segment keeps tx low.
    writeSeg(3'd0, FRQ_A, 32'd5, 2'b11);
    writeSeg(3'd1, FRQ_B, 32'd0, 2'b00);
    writeSeg(3'd2, FRQ_C, 32'd7, 2'b01);
    seq_len = 4'd3; rep_count = 16'd2;
    applyStimulus(1'b1, 1'b0);
    watchRun(200);
    checkOutput("t2_pulse_count", pulses.size(), 4);
    checkOutput("t2_pulse0", pulseAt(0), 5);
    checkOutput("t2_pulse1", pulseAt(1), 7);
    checkOutput("t2_pulse2", pulseAt(2), 5);
    checkOutput("t2_pulse3", pulseAt(3), 7);
    checkOutput("t2_acq_count", acq_cnt, 2);
    checkOutput("t2_max_rep", max_rep, 1);
    checkOutput("t2_final_seg_idx", seg_idx, 3'd2);
    checkOutput("t2_final_rep_idx", rep_idx, 16'd1);
    countExtraDone(4);
    checkOutput("t2_single_done", extra_done, 0);

    // dds_valid held low in SETTLE, then dropped during RUN; rep_count 0 plays once.
    seq_len = 4'd1; rep_count = 16'd0;
    dds_valid = 1'b0;
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    tx_highs = 0;
    for (int i = 0; i < 20; i++) begin
      stepCycle();
      if (tx_gate) tx_highs++;
    end
    checkOutput("t3_tx_low_while_settle", tx_highs, 0);
    checkOutput("t3_busy_while_settle", busy, 1'b1);
    dds_valid = 1'b1;
    stepCycle();
    checkOutput("t3_tx_rises", tx_gate, 1'b1);
    checkOutput("t3_acq_rises", acq_trig, 1'b1);
    dds_valid = 1'b0;
    watchRun(100);
    checkOutput("t3_pulse_len", pulseAt(0), 5);
    checkOutput("t3_max_rep", max_rep, 0);
    dds_valid = 1'b1;

    // Abort in the RUN phase of segment 1, then a clean restart.
    writeSeg(3'd1, FRQ_B, 32'd4, 2'b01);
    seq_len = 4'd3; rep_count = 16'd1;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 50 && !(seg_idx == 3'd1 && tx_gate); i++) stepCycle();
    checkOutput("t4_reached_seg1_run", (seg_idx == 3'd1 && tx_gate), 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t4_abort_tx", tx_gate, 1'b0);
    checkOutput("t4_abort_busy", busy, 1'b0);
    checkOutput("t4_abort_frq", frq_out, 32'h0);
    checkOutput("t4_abort_no_done", done, 1'b0);
    countExtraDone(5);
    checkOutput("t4_no_done_later", extra_done, 0);
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    checkOutput("t4_restart_frq", frq_out, FRQ_A);
    checkOutput("t4_restart_seg", seg_idx, 3'd0);
    watchRun(200);
    checkOutput("t4_restart_pulse0", pulseAt(0), 5);
    checkOutput("t4_restart_pulse1", pulseAt(1), 4);
    checkOutput("t4_restart_pulse2", pulseAt(2), 7);

    // Table writes while busy are dropped; invalid seq_len values are ignored.
    seq_len = 4'd1; rep_count = 16'd1;
    applyStimulus(1'b1, 1'b0);
    writeSeg(3'd0, 32'h1, 32'd5, 2'b11);
    watchRun(100);
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    checkOutput("t5_entry_unchanged", frq_out, FRQ_A);
    watchRun(100);
    seq_len = 4'd0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_len0_busy", busy, 1'b0);
    stepCycle();
    checkOutput("t5_len0_frq", frq_out, 32'h0);
    seq_len = 4'd9;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_len9_busy", busy, 1'b0);

    // Asynchronous reset mid-RUN clears outputs at once and wipes the table.
    seq_len = 4'd1;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 50 && !tx_gate; i++) stepCycle();
    checkOutput("t6_reached_run", tx_gate, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_tx", tx_gate, 1'b0);
    checkOutput("t6_rst_busy", busy, 1'b0);
    checkOutput("t6_rst_frq", frq_out, 32'h0);
    #2;
    rst = 1'b0;
    stepCycle();
    seq_len = 4'd3;
    applyStimulus(1'b1, 1'b0);
    watchRun(200);
    checkOutput("t6_cleared_frq", frq_or, 32'h0);
    checkOutput("t6_cleared_pulses", pulses.size(), 0);
    checkOutput("t6_cleared_acq", acq_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
